// File: rtl/seg7_display_bank.sv
// Registered N-digit 7-segment controller: load handshake, sequential leading-zero blanking, PWM dimming.
// Define SEG7_BLINK_EN to build the per-digit blink counter/phase; otherwise blink_mask is ignored.
module seg7_display_bank #(
    parameter int NUM_DIGITS = 6,
    parameter int PWM_BITS   = 4,
    parameter int BLINK_DIV  = 25_000_000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [4*NUM_DIGITS-1:0]   bcd_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic                      blank_lz,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    input  logic [PWM_BITS-1:0]       brightness,
    output logic [8*NUM_DIGITS-1:0]   hex_out
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic [0:0] {IDLE, SCAN} state_t;

    state_t                 state_q;
    logic [IW-1:0]          idx_q;
    logic                   zeroRun_q;
    logic [3:0]             bcdShadow_q [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]  dpShadow_q;
    logic                   blankLz_q;
    logic [7:0]             staging_q   [NUM_DIGITS];
    logic [7:0]             committed_q [NUM_DIGITS];
    logic [7:0]             hex_q       [NUM_DIGITS];
    logic [7:0]             hex_d       [NUM_DIGITS];
    logic [PWM_BITS-1:0]    pwmCnt_q;
    logic [NUM_DIGITS-1:0]  blinkOff;

    logic [3:0]             curDigit;
    logic                   curDp;
    logic                   blankNow;
    logic [7:0]             glyphNow;
    logic                   pwmOn;

    function automatic logic [7:0] hexGlyph(input logic [3:0] v);
        logic [7:0] g;
        unique case (v)
            4'h0: g = 8'hC0;
            4'h1: g = 8'hF9;
            4'h2: g = 8'hA4;
            4'h3: g = 8'hB0;
            4'h4: g = 8'h99;
            4'h5: g = 8'h92;
            4'h6: g = 8'h82;
            4'h7: g = 8'hF8;
            4'h8: g = 8'h80;
            4'h9: g = 8'h90;
            4'hA: g = 8'h88;
            4'hB: g = 8'h83;
            4'hC: g = 8'hC6;
            4'hD: g = 8'hA1;
            4'hE: g = 8'h86;
            default: g = 8'h8E;
        endcase
        return g;
    endfunction

    assign load_ready = (state_q == IDLE);

    // Digit under scan; a lit dp keeps a zero visible and ends the leading-zero run.
    always_comb begin
        curDigit = bcdShadow_q[idx_q];
        curDp    = dpShadow_q[idx_q];
        blankNow = blankLz_q && zeroRun_q && (curDigit == 4'h0) && !curDp && (idx_q != '0);
        glyphNow = blankNow ? 8'hFF : (hexGlyph(curDigit) & {~curDp, 7'h7F});
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            zeroRun_q  <= 1'b1;
            dpShadow_q <= '1;
            blankLz_q  <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                bcdShadow_q[i] <= 4'hF;
                staging_q[i]   <= 8'hFF;
                committed_q[i] <= 8'hFF;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (load_valid) begin
                        for (int i = 0; i < NUM_DIGITS; i++) begin
                            bcdShadow_q[i] <= bcd_in[4*i +: 4];
                        end
                        dpShadow_q <= dp_in;
                        blankLz_q  <= blank_lz;
                        idx_q      <= IW'(NUM_DIGITS - 1);
                        zeroRun_q  <= 1'b1;
                        state_q    <= SCAN;
                    end
                end
                SCAN: begin
                    staging_q[idx_q] <= glyphNow;
                    if (!blankNow) begin
                        zeroRun_q <= 1'b0;
                    end
                    // Digit 0 is still in flight this cycle, so it is committed straight from glyphNow.
                    if (idx_q == '0) begin
                        for (int i = 0; i < NUM_DIGITS; i++) begin
                            committed_q[i] <= (i == 0) ? glyphNow : staging_q[i];
                        end
                        state_q <= IDLE;
                    end else begin
                        idx_q <= idx_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SEG7_BLINK_EN
    localparam int BW = $clog2(BLINK_DIV);

    logic [BW-1:0] blinkCnt_q;
    logic          blinkPhase_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blinkCnt_q   <= '0;
            blinkPhase_q <= 1'b0;
        end else if (blinkCnt_q == BW'(BLINK_DIV - 1)) begin
            blinkCnt_q   <= '0;
            blinkPhase_q <= ~blinkPhase_q;
        end else begin
            blinkCnt_q <= blinkCnt_q + 1'b1;
        end
    end

    assign blinkOff = blinkPhase_q ? blink_mask : '0;
`else
    localparam int unusedBlinkDiv = BLINK_DIV;
    logic unusedBlinkMask;

    assign unusedBlinkMask = ^blink_mask;
    assign blinkOff        = '0;
`endif

    assign pwmOn = (brightness == '1) || (pwmCnt_q < brightness);

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            hex_d[i] = (pwmOn && !blinkOff[i]) ? committed_q[i] : 8'hFF;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwmCnt_q <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                hex_q[i] <= 8'hFF;
            end
        end else begin
            pwmCnt_q <= pwmCnt_q + 1'b1;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                hex_q[i] <= hex_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            hex_out[8*i +: 8] = hex_q[i];
        end
    end

endmodule

// File: tb/tb_seg7_display_bank.sv
// Directed self-checking bench for seg7_display_bank (6 digits, 4-bit PWM, short blink period).
// Covers blink behaviour both with and without SEG7_BLINK_EN.
module tb_seg7_display_bank;

    localparam int N = 6;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [4*N-1:0]  bcd_in;
    logic [N-1:0]    dp_in;
    logic            load_valid;
    logic            load_ready;
    logic            blank_lz;
    logic [N-1:0]    blink_mask;
    logic [3:0]      brightness;
    logic [8*N-1:0]  hex_out;

    int checks   = 0;
    int failures = 0;
    logic [47:0] lastExpected;

    seg7_display_bank #(
        .NUM_DIGITS (N),
        .PWM_BITS   (4),
        .BLINK_DIV  (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .blank_lz   (blank_lz),
        .blink_mask (blink_mask),
        .brightness (brightness),
        .hex_out    (hex_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One load: accept edge, N scan edges, then the registered output edge.
    task automatic applyStimulus(input logic [23:0] bcd, input logic [5:0] dp, input logic blz,
                                 input logic [47:0] expNew, input string tag);
        int waitCycles = 0;
        while (!load_ready && waitCycles < 20) begin
            tick();
            waitCycles++;
        end
        checkOutput({tag, "_readyBefore"}, 64'(load_ready), 64'd1);
        bcd_in     = bcd;
        dp_in      = dp;
        blank_lz   = blz;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        bcd_in     = ~bcd;
        dp_in      = ~dp;
        checkOutput({tag, "_readyLowAfterAccept"}, 64'(load_ready), 64'd0);
        repeat (N - 1) tick();
        checkOutput({tag, "_readyLowLastScan"}, 64'(load_ready), 64'd0);
        tick();
        checkOutput({tag, "_readyHighAfterCommit"}, 64'(load_ready), 64'd1);
        checkOutput({tag, "_hexOldAtCommit"}, 64'(hex_out), 64'(lastExpected));
        tick();
        checkOutput({tag, "_hexNew"}, 64'(hex_out), 64'(expNew));
        lastExpected = expNew;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int accepts;
        int lowCount;
        int onCnt0;
        int onCnt5;
        int offCnt;
        int steadyCnt;
        int altCnt;
        logic [23:0] lastAcc;
        logic shown [16];

        reset_n    = 1'b0;
        bcd_in     = '0;
        dp_in      = '0;
        load_valid = 1'b0;
        blank_lz   = 1'b0;
        blink_mask = '0;
        brightness = 4'hF;
        lastExpected = 48'hFFFF_FFFF_FFFF;

        #12;
        checkOutput("resetHex", 64'(hex_out), 64'hFFFF_FFFF_FFFF);
        checkOutput("resetReady", 64'(load_ready), 64'd1);
        tick();
        reset_n = 1'b1;
        tick();

        applyStimulus(24'h000120, 6'b000000, 1'b1, 48'hFFFF_FFF9_A4C0, "lzOn");
        applyStimulus(24'h000120, 6'b000000, 1'b0, 48'hC0C0_C0F9_A4C0, "lzOff");
        applyStimulus(24'h000000, 6'b000100, 1'b1, 48'hFFFF_FF40_C0C0, "dpZero");
        applyStimulus(24'h000000, 6'b000000, 1'b1, 48'hFFFF_FFFF_FFC0, "allZero");
        applyStimulus(24'h050009, 6'b000000, 1'b1, 48'hFF92_C0C0_C090, "midZero");
        applyStimulus(24'hFEDCBA, 6'b100001, 1'b1, 48'h0E86_A1C6_8308, "hexAll");

        // Abort a scan with reset; the partial load must never appear.
        bcd_in     = 24'h123456;
        dp_in      = '0;
        blank_lz   = 1'b0;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        checkOutput("midScanResetHex", 64'(hex_out), 64'hFFFF_FFFF_FFFF);
        checkOutput("midScanResetReady", 64'(load_ready), 64'd1);
        tick();
        checkOutput("resetHeldHex", 64'(hex_out), 64'hFFFF_FFFF_FFFF);
        reset_n = 1'b1;
        repeat (8) tick();
        checkOutput("afterAbortHex", 64'(hex_out), 64'hFFFF_FFFF_FFFF);
        checkOutput("afterAbortReady", 64'(load_ready), 64'd1);
        lastExpected = 48'hFFFF_FFFF_FFFF;
        applyStimulus(24'h000120, 6'b000000, 1'b1, 48'hFFFF_FFF9_A4C0, "reload");

        // Continuous load_valid with data changing every cycle.
        accepts  = 0;
        lowCount = 0;
        lastAcc  = '0;
        blank_lz = 1'b0;
        dp_in    = '0;
        load_valid = 1'b1;
        for (int k = 0; k < 21; k++) begin
            bcd_in = 24'h987650 + 24'(k);
            if (load_ready) begin
                accepts++;
                lastAcc = bcd_in;
            end else begin
                lowCount++;
            end
            tick();
        end
        load_valid = 1'b0;
        tick();
        checkOutput("hsAccepts", 64'(accepts), 64'd3);
        checkOutput("hsReadyLow", 64'(lowCount), 64'd18);
        checkOutput("hsLastCaptured", 64'(lastAcc), 64'h98765E);
        checkOutput("hsDisplayed", 64'(hex_out), 64'h9080_F882_9286);
        lastExpected = 48'h9080_F882_9286;

        // PWM duty 4/16.
        brightness = 4'd4;
        tick();
        onCnt0 = 0;
        onCnt5 = 0;
        offCnt = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (hex_out[7:0] == 8'h86) onCnt0++;
            if (hex_out[47:40] == 8'h90) onCnt5++;
            if (hex_out == 48'hFFFF_FFFF_FFFF) offCnt++;
        end
        checkOutput("pwm4Digit0On", 64'(onCnt0), 64'd4);
        checkOutput("pwm4Digit5On", 64'(onCnt5), 64'd4);
        checkOutput("pwm4Off", 64'(offCnt), 64'd12);

        brightness = 4'd0;
        tick();
        checkOutput("pwm0Latency", 64'(hex_out), 64'hFFFF_FFFF_FFFF);
        offCnt = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (hex_out == 48'hFFFF_FFFF_FFFF) offCnt++;
        end
        checkOutput("pwm0Off", 64'(offCnt), 64'd16);

        brightness = 4'hF;
        tick();
        checkOutput("pwmFullOn", 64'(hex_out), 64'(lastExpected));

        // Blink digit 0 only.
        blink_mask = 6'b000001;
        tick();
        onCnt0    = 0;
        steadyCnt = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            shown[k] = (hex_out[7:0] == 8'h86);
            if (shown[k]) onCnt0++;
            if (hex_out[47:8] == 40'h9080_F88292) steadyCnt++;
        end
        altCnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (shown[k] != shown[k + 4]) altCnt++;
        end
        checkOutput("blinkOthersSteady", 64'(steadyCnt), 64'd16);
`ifdef SEG7_BLINK_EN
        checkOutput("blinkDigit0On", 64'(onCnt0), 64'd8);
        checkOutput("blinkAlternate", 64'(altCnt), 64'd12);
`else
        checkOutput("noBlinkDigit0On", 64'(onCnt0), 64'd16);
        checkOutput("noBlinkAlternate", 64'(altCnt), 64'd0);
`endif
        blink_mask = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_display_bank.md
# seg7_display_bank

Parametrised, registered 7-segment display controller for N hex digits with a load handshake, sequential leading-zero blanking, per-digit decimal points, PWM brightness and optional per-digit blinking. It takes a packed BCD/hex word plus control from the application core. It drives the board's active-low HEX segment outputs directly. It supersedes the fixed six-digit combinational decoder bank.

## Interface
Parameters:
- NUM_DIGITS, 6, number of digits driven (1..16)
- PWM_BITS, 4, width of brightness control and PWM counter
- BLINK_DIV, 25_000_000, clk cycles per blink half-period (≥2)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- bcd_in  in  4*NUM_DIGITS  digit i at [4i+3:4i], digit 0 rightmost, values 0..15
- dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit
- load_valid  in  1  request to capture bcd_in/dp_in/blank_lz
- load_ready  out  1  controller idle, can accept a load
- blank_lz  in  1  enable leading-zero blanking for this load
- blink_mask  in  NUM_DIGITS  live per-digit blink enable (not captured)
- brightness  in  PWM_BITS  live duty setting; 0 = off, all-ones = fully on
- hex_out  out  8*NUM_DIGITS  digit i at [8i+7:8i], bit order {dp,g,f,e,d,c,b,a}, active-low

## Operation
- FSM states: IDLE, SCAN. load_ready = (state == IDLE).
- IDLE: on load_valid && load_ready, capture bcd_in, dp_in and blank_lz into shadow registers. Set scan index to NUM_DIGITS-1 and a zero-run flag to 1. Go to SCAN.
- SCAN: one digit per cycle, MSB to LSB. Digit is blanked iff captured blank_lz=1, zero-run=1, value==0, dp==0 and index≠0. Any non-blanked digit clears zero-run. The glyph (or 8'hFF if blanked) is written into a staging array. After index 0, copy staging to the committed array and return to IDLE.
- Digit 0 is never blanked. All-zero input with blank_lz=1 shows a single "0".
- Glyphs are hex, dp off: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E. A lit dp clears bit 7.
- PWM: free-running PWM_BITS counter. Segments are enabled when counter < brightness, or when brightness is all-ones.
- Gating: hex_out digit = committed glyph when enabled; otherwise 8'hFF. Gating is re-evaluated every cycle from the live brightness and blink_mask.
- load_valid while in SCAN is ignored and nothing is captured. Committed data and hex_out are unchanged until the scan completes.

## Timing
- Reset (async assert, sync release): state IDLE, load_ready=1, shadow/staging/committed arrays = 8'hFF, hex_out all ones (all off), PWM counter 0, blink counter 0, blink phase 0.
- Accept edge = cycle 0. SCAN occupies cycles 1..NUM_DIGITS. The committed array updates on edge NUM_DIGITS, and load_ready is high again after it.
- hex_out is registered and reflects the new value on edge NUM_DIGITS+1. Back-to-back loads give one accept per NUM_DIGITS+1 cycles.
- Brightness and blink_mask changes reach hex_out with 1-cycle latency.
- Reset asserted mid-SCAN aborts the scan. The partial load is discarded and all outputs return to reset values.

## Configuration
- SEG7_BLINK_EN defined: the blink counter counts 0..BLINK_DIV-1 and toggles blink phase on wrap. While phase=1, digits with blink_mask[i]=1 are forced to 8'hFF.
- SEG7_BLINK_EN undefined: the blink counter and phase are not built and blink_mask is ignored. All other behaviour is identical.

## Test plan
- Reset with outputs checked mid-SCAN: hex_out = all FF, load_ready=1 during and after reset. A new load then completes normally.
- NUM_DIGITS=6, brightness=F, load bcd_in=24'h000120, dp_in=0, blank_lz=1: after 7 cycles hex_out = {FF,FF,FF,F9,A4,C0}. With blank_lz=0: {C0,C0,C0,F9,A4,C0}.
- Load 24'h000000, dp_in=6'b000100, blank_lz=1: digit 2 = 40 (0 with dp), digits 1 and 0 = C0, digits 5..3 = FF.
- Handshake: hold load_valid high with a changing bcd_in. Exactly one capture per 7 cycles, load_ready low on cycles 1..6, and the values presented during SCAN are never displayed.
- brightness=4 (PWM_BITS=4): over 16 cycles each digit shows its glyph for exactly 4 cycles and FF for 12. With brightness=0 it is always FF.
- With SEG7_BLINK_EN, BLINK_DIV=4, blink_mask=6'b000001: digit 0 alternates glyph/FF every 4 cycles while the other digits stay steady. Without the macro, digit 0 stays steady.
